// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin scheduler sharing one FP multiplier among NREQ
// requesters, with a per-operation watchdog. All outputs are registered.
module fp_mul_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_op1,
  input  logic [NREQ*32-1:0]   req_op2,
  output logic [NREQ-1:0]      req_grant,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [31:0]          mul_op1,
  output logic [31:0]          mul_op2,
  input  logic [31:0]          mul_result,
  input  logic                 mul_overflow,
  input  logic                 mul_done
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tmo_q, tmo_d;
  logic [31:0]     op1_q, op1_d, op2_q, op2_d;
  logic [31:0]     res_q, res_d;
  logic            ovf_q, ovf_d, err_q, err_d;
  logic            start_q, start_d, busy_q, busy_d;
  logic [NREQ-1:0] grant_q, grant_d, rspv_q, rspv_d;

  logic [PW-1:0]   sel, cand;
  logic            found;

  // Round-robin pick: first requester at or above rr_q, wrapping explicitly.
  always_comb begin
    sel   = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + PW'(1);
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      tmo_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      rspv_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      rspv_q  <= rspv_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    tmo_d   = tmo_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          idx_d   = sel;
          op1_d   = req_op1[32*sel +: 32];
          op2_d   = req_op2[32*sel +: 32];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        tmo_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Reaching TIMEOUT-1 arms the watchdog; it fires one WAIT cycle later,
        // so the timeout response lands TIMEOUT+2 cycles after ISSUE.
        if (mul_done) begin
          res_d   = mul_result;
          ovf_d   = mul_overflow;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo_q) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          tmo_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        rr_d    = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
    grant_d = (state_d == S_ISSUE) ? (NREQ'(1) << idx_d) : '0;
    rspv_d  = (state_d == S_RESP)  ? (NREQ'(1) << idx_q) : '0;
  end

  assign req_grant    = grant_q;
  assign rsp_valid    = rspv_q;
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_err      = err_q;
  assign busy         = busy_q;
  assign mul_start    = start_q;
  assign mul_op1      = op1_q;
  assign mul_op2      = op2_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Scoreboard bench for fp_mul_sched: directed requests, a behavioural
// multiplier stub, and a monitor that checks every response against the queue.
module tb_fp_mul_sched;

  localparam int NREQ = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_op1, req_op2;
  logic [NREQ-1:0]    req_grant, rsp_valid;
  logic [31:0]        rsp_result, mul_op1, mul_op2;
  logic               rsp_overflow, rsp_err, busy, mul_start;
  logic [31:0]        mul_result = '0;
  logic               mul_overflow = 1'b0;
  logic               mul_done = 1'b0;

  fp_mul_sched #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op1(req_op1),
    .req_op2(req_op2), .req_grant(req_grant), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_result(mul_result), .mul_overflow(mul_overflow), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] op1_tab[NREQ];
  logic [31:0] op2_tab[NREQ];
  int          done_mode = 0;   // 0: done tied high, 1: never, 2: pulse in WAIT cycle done_at
  int          done_at   = 5;
  logic        stray     = 1'b0;
  int          pend      = 0;
  int          wcnt      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [31:0] r, input logic o, input logic e);
    exp_t x;
    x.idx = i; x.res = r; x.ovf = o; x.err = e;
    sb.push_back(x);
  endtask

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_op1[32*i +: 32] = op1_tab[i];
      req_op2[32*i +: 32] = op2_tab[i];
    end
  endtask

  // Hand-computed IEEE-754 products for the operand pairs used below.
  function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3FA00000_3FC00000: fmul = {1'b0, 32'h3FF00000};  // 1.25 * 1.5
      64'h40000000_40400000: fmul = {1'b0, 32'h40C00000};  // 2.0 * 3.0
      64'h3F000000_40800000: fmul = {1'b0, 32'h40000000};  // 0.5 * 4.0
      64'h3F800000_C0200000: fmul = {1'b0, 32'hC0200000};  // 1.0 * -2.5
      64'h7F000000_7F000000: fmul = {1'b1, 32'h7F800000};  // overflow -> +inf
      default:               fmul = {1'b0, a ^ b};
    endcase
  endfunction

  // Multiplier stub: counts WAIT cycles after mul_start and drives mul_done.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0; wcnt = 0;
    end else if (mul_start) begin
      pend = 1; wcnt = 0;
    end else if (pend != 0) begin
      wcnt++;
    end
    {mul_overflow, mul_result} = fmul(mul_op1, mul_op2);
    mul_done = (done_mode == 0) || stray ||
               (done_mode == 2 && pend != 0 && wcnt == done_at);
    if (pend != 0 && wcnt == done_at) pend = 0;
  end

  // Monitor: every response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_rsp_valid", 32'(rsp_valid), 32'(1) << x.idx);
        chk("sb_result", rsp_result, x.res);
        chk("sb_overflow", 32'(rsp_overflow), 32'(x.ovf));
        chk("sb_err", 32'(rsp_err), 32'(x.err));
      end
    end
  end

  // Wait for the grant, then the response, checking their timing; drop the request.
  task automatic serve(input int i, input int exp_gw, input int exp_lat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!mul_start && n < 50);
    if (exp_gw >= 0) chk("grant_delay", n, exp_gw);
    chk("grant", 32'(req_grant), 32'(1) << i);
    chk("busy_issue", 32'(busy), 32'h1);
    chk("mul_op1", mul_op1, op1_tab[i]);
    chk("mul_op2", mul_op2, op2_tab[i]);
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 50);
    chk("rsp_onehot", 32'(rsp_valid), 32'(1) << i);
    if (exp_lat >= 0) chk("rsp_latency", n, exp_lat);
    req_valid[i] = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_start"}, 32'(mul_start), 32'h0);
    chk({tag, "_grant"}, 32'(req_grant), 32'h0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_op1"}, mul_op1, 32'h0);
    chk({tag, "_op2"}, mul_op2, 32'h0);
    chk({tag, "_result"}, rsp_result, 32'h0);
    chk({tag, "_ovf_err"}, {30'h0, rsp_overflow, rsp_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0;
    op1_tab = '{32'h3FA00000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    op2_tab = '{32'h3FC00000, 32'h40400000, 32'h40800000, 32'hC0200000};
    load_ops();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single request, done in first WAIT cycle.
    @(negedge clk);
    req_valid[0] = 1'b1;
    push(0, 32'h3FF00000, 1'b0, 1'b0);
    serve(0, 1, 2);
    @(negedge clk);
    chk("idle_after_resp", 32'(busy), 32'h0);

    // Round-robin over all four from rr_ptr = 0, then 2 alone.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = '1;
    push(0, 32'h3FF00000, 1'b0, 1'b0);
    push(1, 32'h40C00000, 1'b0, 1'b0);
    push(2, 32'h40000000, 1'b0, 1'b0);
    push(3, 32'hC0200000, 1'b0, 1'b0);
    serve(0, 1, 2);
    serve(1, 2, 2);
    serve(2, 2, 2);
    serve(3, 2, 2);
    req_valid[2] = 1'b1;
    push(2, 32'h40000000, 1'b0, 1'b0);
    serve(2, 2, 2);

    // Wrap: rr_ptr = 3, requests on 1 and 3.
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    push(3, 32'hC0200000, 1'b0, 1'b0);
    push(1, 32'h40C00000, 1'b0, 1'b0);
    serve(3, 2, 2);
    serve(1, 2, 2);

    // Timeout: rr_ptr = 2 so 3 wins over 0; 0 then completes normally.
    done_mode = 1;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    push(3, 32'h0, 1'b0, 1'b1);
    push(0, 32'h3FF00000, 1'b0, 1'b0);
    serve(3, 2, 18);
    done_mode = 0;
    serve(0, 2, 2);

    // Late done with overflow on requester 2, then a stray done in IDLE.
    op1_tab[2] = 32'h7F000000;
    op2_tab[2] = 32'h7F000000;
    load_ops();
    done_mode = 2;
    done_at = 5;
    req_valid[2] = 1'b1;
    push(2, 32'h7F800000, 1'b1, 1'b0);
    serve(2, 2, 6);
    done_mode = 1;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_busy", 32'(busy), 32'h0);
    chk("stray_rspv", 32'(rsp_valid), 32'h0);
    chk("held_result", rsp_result, 32'h7F800000);
    chk("held_overflow", 32'(rsp_overflow), 32'h1);

    // Reset during WAIT: no response, then arbitration restarts from 0.
    req_valid[3] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mul_start && n < 50);
    chk("pre_reset_grant", 32'(req_grant), 32'h8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    done_mode = 0;
    req_valid[1] = 1'b1;
    push(1, 32'h40C00000, 1'b0, 1'b0);
    push(3, 32'hC0200000, 1'b0, 1'b0);
    serve(1, 1, 2);
    serve(3, 2, 2);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
